// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//   Two-master AHB-Lite arbiter in front of the single master port of the
//   decoder/mux fabric. Master 0 is the Cortex-M0, master 1 the DMA/accelerator.
//   Each master has a one-entry address input stage. A transfer issued while
//   the master is not granted is accepted into that stage, and the stage
//   replays it as a NONSEQ once the master owns the bus. Ownership is
//   request-driven, with a hold limit that forces the grant over after
//   MAX_HOLD accepted owner transfers while the other master is waiting.
//
// Ports
//   clk, reset                 bus clock, synchronous active-high reset
//   mX_HADDR..mX_HWDATA        address/control/write data from master X
//   mX_HRDATA/HREADY/HRESP     response path to master X
//   s_HADDR..s_HWDATA          shared bus towards the decoder and slaves
//   s_HRDATA/HREADY/HRESP      shared response from the mux
//   grant                      current address-phase owner
module ahb_master_arbiter #(
  parameter int unsigned RESET_OWNER = 0,
  parameter int unsigned MAX_HOLD    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [3:0]  m0_HPROT,
  input  logic [31:0] m0_HWDATA,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [3:0]  m1_HPROT,
  input  logic [31:0] m1_HWDATA,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,
  output logic [31:0] s_HADDR,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [2:0]  s_HSIZE,
  output logic [3:0]  s_HPROT,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP,
  output logic        grant
);

  localparam logic       RST_GRANT = 1'(RESET_OWNER);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // Live master signals gathered into arrays indexed by master number.
  logic [1:0][31:0] m_haddr;
  logic [1:0][1:0]  m_htrans;
  logic [1:0]       m_hwrite;
  logic [1:0][2:0]  m_hsize;
  logic [1:0][3:0]  m_hprot;
  logic [1:0][31:0] m_hwdata;

  assign m_haddr  = {m1_HADDR, m0_HADDR};
  assign m_htrans = {m1_HTRANS, m0_HTRANS};
  assign m_hwrite = {m1_HWRITE, m0_HWRITE};
  assign m_hsize  = {m1_HSIZE, m0_HSIZE};
  assign m_hprot  = {m1_HPROT, m0_HPROT};
  assign m_hwdata = {m1_HWDATA, m0_HWDATA};

  // Control state.
  logic       grant_q, grant_d;
  logic [1:0] pend_v_q, pend_v_d;
  logic       dv_q, dv_d;
  logic       down_q, down_d;
  logic [3:0] hold_q, hold_d;

  // Input-stage payload (no reset needed, qualified by pend_v_q).
  logic [1:0][31:0] pend_addr_q;
  logic [1:0]       pend_write_q;
  logic [1:0][2:0]  pend_size_q;
  logic [1:0][3:0]  pend_prot_q;

  logic [1:0] m_hready;
  logic [1:0] cap;
  logic [1:0] req;
  logic       use_pend;
  logic       req_own, req_oth;

  // A master is stalled while its input stage is occupied; otherwise it
  // tracks the shared bus whenever it owns the address or data phase, and
  // is free-running (always ready) when it has nothing on the bus.
  assign m_hready[0] = pend_v_q[0] ? 1'b0 :
                       (((dv_q && !down_q) || !grant_q) ? s_HREADY : 1'b1);
  assign m_hready[1] = pend_v_q[1] ? 1'b0 :
                       (((dv_q &&  down_q) ||  grant_q) ? s_HREADY : 1'b1);

  assign cap[0] = m_hready[0] && m_htrans[0][1] &&  grant_q;
  assign cap[1] = m_hready[1] && m_htrans[1][1] && !grant_q;

  assign req     = pend_v_q | {m_htrans[1][1], m_htrans[0][1]};
  assign req_own = req[grant_q];
  assign req_oth = req[~grant_q];

  // Shared address/control: a replayed entry always goes out as NONSEQ.
  assign use_pend = pend_v_q[grant_q];
  assign s_HADDR  = use_pend ? pend_addr_q[grant_q]  : m_haddr[grant_q];
  assign s_HTRANS = use_pend ? 2'b10                 : m_htrans[grant_q];
  assign s_HWRITE = use_pend ? pend_write_q[grant_q] : m_hwrite[grant_q];
  assign s_HSIZE  = use_pend ? pend_size_q[grant_q]  : m_hsize[grant_q];
  assign s_HPROT  = use_pend ? pend_prot_q[grant_q]  : m_hprot[grant_q];
  assign s_HWDATA = m_hwdata[down_q];

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HREADY = m_hready[0];
  assign m1_HREADY = m_hready[1];
  assign m0_HRESP  = dv_q && !down_q && s_HRESP;
  assign m1_HRESP  = dv_q &&  down_q && s_HRESP;
  assign grant     = grant_q;

  always_comb begin
    grant_d  = grant_q;
    pend_v_d = pend_v_q;
    dv_d     = dv_q;
    down_d   = down_q;
    hold_d   = hold_q;
    if (s_HREADY) begin
      dv_d   = s_HTRANS[1];
      down_d = grant_q;
      if (use_pend) begin
        pend_v_d[grant_q] = 1'b0;
      end
      if (!req_oth) begin
        hold_d = '0;
      end else if (!req_own) begin
        grant_d = ~grant_q;
        hold_d  = '0;
      end else if (s_HTRANS[1]) begin
        // Both requesting: the owner's transfer on this edge is accepted
        // even when it is the one that exhausts the hold budget.
        if (hold_q == HOLD_LAST) begin
          grant_d = ~grant_q;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
    end
    // Capture only happens for the non-owner, release only for the owner,
    // so the two never touch the same entry on one edge.
    pend_v_d = pend_v_d | cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= RST_GRANT;
      pend_v_q <= '0;
      dv_q     <= 1'b0;
      down_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      pend_v_q <= pend_v_d;
      dv_q     <= dv_d;
      down_q   <= down_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        pend_addr_q[i]  <= m_haddr[i];
        pend_write_q[i] <= m_hwrite[i];
        pend_size_q[i]  <= m_hsize[i];
        pend_prot_q[i]  <= m_hprot[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios plus a two-master
// back-to-back run checked against per-master address queues.
module tb_ahb_master_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_HADDR, m1_HADDR;
  logic [1:0]  m0_HTRANS, m1_HTRANS;
  logic        m0_HWRITE, m1_HWRITE;
  logic [2:0]  m0_HSIZE, m1_HSIZE;
  logic [3:0]  m0_HPROT, m1_HPROT;
  logic [31:0] m0_HWDATA, m1_HWDATA;
  logic [31:0] m0_HRDATA, m1_HRDATA;
  logic        m0_HREADY, m1_HREADY;
  logic        m0_HRESP, m1_HRESP;
  logic [31:0] s_HADDR;
  logic [1:0]  s_HTRANS;
  logic        s_HWRITE;
  logic [2:0]  s_HSIZE;
  logic [3:0]  s_HPROT;
  logic [31:0] s_HWDATA;
  logic [31:0] s_HRDATA;
  logic        s_HREADY;
  logic        s_HRESP;
  logic        grant;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  ahb_master_arbiter #(.RESET_OWNER(0), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE),
    .m0_HSIZE(m0_HSIZE), .m0_HPROT(m0_HPROT), .m0_HWDATA(m0_HWDATA),
    .m0_HRDATA(m0_HRDATA), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
    .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE),
    .m1_HSIZE(m1_HSIZE), .m1_HPROT(m1_HPROT), .m1_HWDATA(m1_HWDATA),
    .m1_HRDATA(m1_HRDATA), .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP),
    .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HPROT(s_HPROT), .s_HWDATA(s_HWDATA),
    .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx0, idx1, k;
    logic rdy0, rdy1;

    reset = 1'b1;
    m0_HADDR = '0; m0_HTRANS = 2'b00; m0_HWRITE = 1'b0; m0_HSIZE = 3'd2;
    m0_HPROT = 4'h3; m0_HWDATA = '0;
    m1_HADDR = '0; m1_HTRANS = 2'b00; m1_HWRITE = 1'b0; m1_HSIZE = 3'd2;
    m1_HPROT = 4'h3; m1_HWDATA = '0;
    s_HRDATA = '0; s_HREADY = 1'b1; s_HRESP = 1'b0;

    // Reset state
    step; step;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_htrans", s_HTRANS, 0);
    chk("rst_m0_ready", m0_HREADY, 1);
    chk("rst_m1_ready", m1_HREADY, 1);
    chk("rst_m0_resp", m0_HRESP, 0);
    chk("rst_m1_resp", m1_HRESP, 0);

    // m1 read through the input stage
    step;
    m1_HADDR = 32'h2000_0010; m1_HTRANS = 2'b10; m1_HWRITE = 1'b0;
    @(negedge clk);
    chk("rd_m1_ready_issue", m1_HREADY, 1);
    step;
    m1_HTRANS = 2'b00;
    @(negedge clk);
    chk("rd_m1_ready_pend", m1_HREADY, 0);
    chk("rd_grant", grant, 1);
    chk("rd_haddr", s_HADDR, 32'h2000_0010);
    chk("rd_htrans", s_HTRANS, 2'b10);
    step;
    s_HRDATA = 32'h1234_5678;
    @(negedge clk);
    chk("rd_hrdata", m1_HRDATA, 32'h1234_5678);
    chk("rd_m1_ready_data", m1_HREADY, 1);
    chk("rd_m1_resp", m1_HRESP, 0);

    // Reset with a pending m1 entry and an m0 data phase in flight
    step;
    s_HRDATA = '0;
    m0_HADDR = 32'h3000_0000; m0_HTRANS = 2'b10; m0_HWRITE = 1'b0;
    step;
    m0_HTRANS = 2'b00;
    @(negedge clk);
    chk("mr_grant0", grant, 0);
    chk("mr_haddr", s_HADDR, 32'h3000_0000);
    step;
    m1_HADDR = 32'h2000_0030; m1_HTRANS = 2'b10; s_HREADY = 1'b0;
    @(negedge clk);
    chk("mr_m1_ready_issue", m1_HREADY, 1);
    chk("mr_m0_wait", m0_HREADY, 0);
    step;
    m1_HTRANS = 2'b00; reset = 1'b1;
    @(negedge clk);
    chk("mr_m1_pend", m1_HREADY, 0);
    step;
    reset = 1'b0; s_HREADY = 1'b1; s_HRESP = 1'b1;
    @(negedge clk);
    chk("mr_m1_ready", m1_HREADY, 1);
    chk("mr_m0_ready", m0_HREADY, 1);
    chk("mr_grant", grant, 0);
    chk("mr_htrans", s_HTRANS, 0);
    chk("mr_m0_resp", m0_HRESP, 0);
    chk("mr_m1_resp", m1_HRESP, 0);

    // m0 write with three wait states while m1 requests
    step;
    s_HRESP = 1'b0;
    m0_HADDR = 32'h5000_0000; m0_HTRANS = 2'b10; m0_HWRITE = 1'b1;
    step;
    m0_HTRANS = 2'b00; m0_HWRITE = 1'b0; m0_HWDATA = 32'hCAFE_F00D;
    m1_HADDR = 32'h2000_0020; m1_HTRANS = 2'b10; m1_HWRITE = 1'b0;
    s_HREADY = 1'b0;
    @(negedge clk);
    chk("wr_hwdata_w1", s_HWDATA, 32'hCAFE_F00D);
    chk("wr_grant_w1", grant, 0);
    chk("wr_m0_wait", m0_HREADY, 0);
    step;
    m1_HTRANS = 2'b00;
    @(negedge clk);
    chk("wr_hwdata_w2", s_HWDATA, 32'hCAFE_F00D);
    chk("wr_grant_w2", grant, 0);
    chk("wr_m1_pend_w2", m1_HREADY, 0);
    step;
    @(negedge clk);
    chk("wr_hwdata_w3", s_HWDATA, 32'hCAFE_F00D);
    chk("wr_grant_w3", grant, 0);
    chk("wr_m1_pend_w3", m1_HREADY, 0);
    step;
    s_HREADY = 1'b1;
    @(negedge clk);
    chk("wr_hwdata_done", s_HWDATA, 32'hCAFE_F00D);
    chk("wr_grant_done", grant, 0);
    chk("wr_m0_ready_done", m0_HREADY, 1);
    step;
    m0_HWDATA = '0;
    @(negedge clk);
    chk("wr_grant_sw", grant, 1);
    chk("wr_m1_haddr", s_HADDR, 32'h2000_0020);
    chk("wr_m1_htrans", s_HTRANS, 2'b10);

    // ERROR response during m1 data phase
    step;
    s_HRESP = 1'b1; s_HREADY = 1'b0;
    @(negedge clk);
    chk("err_m1_resp_1", m1_HRESP, 1);
    chk("err_m0_resp_1", m0_HRESP, 0);
    step;
    s_HREADY = 1'b1;
    @(negedge clk);
    chk("err_m1_resp_2", m1_HRESP, 1);
    chk("err_m0_resp_2", m0_HRESP, 0);
    chk("err_m1_ready_2", m1_HREADY, 1);
    step;
    s_HRESP = 1'b0;

    // Back-to-back from both masters, fairness limit 4
    reset = 1'b1;
    step; step;
    reset = 1'b0;
    idx0 = 0; idx1 = 0; k = 0;
    for (int cyc = 0; cyc < 100 && k < 24; cyc++) begin
      m0_HTRANS = (idx0 < 12) ? 2'b10 : 2'b00;
      m0_HADDR  = 32'h1000_0000 + 32'(idx0 * 4);
      m1_HTRANS = (idx1 < 12) ? 2'b10 : 2'b00;
      m1_HADDR  = 32'h2000_0000 + 32'(idx1 * 4);
      @(negedge clk);
      rdy0 = m0_HREADY;
      rdy1 = m1_HREADY;
      if (rdy0 && idx0 < 12) exp_q0.push_back(m0_HADDR);
      if (rdy1 && idx1 < 12) exp_q1.push_back(m1_HADDR);
      if (s_HTRANS[1] && s_HREADY) begin
        chk("b2b_owner", grant, 32'((k / 4) % 2));
        if (grant == 1'b0) begin
          chk("b2b_q0_avail", exp_q0.size() != 0, 1);
          if (exp_q0.size() != 0) chk("b2b_addr0", s_HADDR, exp_q0.pop_front());
        end else begin
          chk("b2b_q1_avail", exp_q1.size() != 0, 1);
          if (exp_q1.size() != 0) chk("b2b_addr1", s_HADDR, exp_q1.pop_front());
        end
        k++;
      end
      step;
      if (rdy0 && idx0 < 12) idx0++;
      if (rdy1 && idx1 < 12) idx1++;
    end
    m0_HTRANS = 2'b00;
    m1_HTRANS = 2'b00;
    chk("b2b_count", 32'(k), 24);
    chk("b2b_q0_left", 32'(exp_q0.size()), 0);
    chk("b2b_q1_left", 32'(exp_q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
